// File: rtl/dmem_mmio_bridge.sv
// Data-side endpoint for the core's MEM stage: word-addressed RAM plus an MMIO block
// with GPIO, a free-running timer with compare flag, and a 4-entry UART TX byte FIFO.
module dmem_mmio_bridge #(
  parameter int unsigned DMEM_AW       = 8,
  parameter logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wmem,
  output logic [31:0] o_rdata,
  output logic [31:0] o_gpio,
  output logic        o_timer_irq,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  localparam int unsigned DW         = 32;
  localparam int unsigned BW         = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PW         = 2;
  localparam int unsigned CW         = 3;
  localparam int unsigned DMEM_WORDS = 1 << DMEM_AW;

  localparam logic [2:0] REG_GPIO   = 3'd0;
  localparam logic [2:0] REG_TCOUNT = 3'd1;
  localparam logic [2:0] REG_TCMP   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_TX     = 3'd4;

  logic [DW-1:0] r_ram [DMEM_WORDS];

  logic [DW-1:0] r_tcount;
  logic [DW-1:0] r_tcmp;
  logic          r_match;
  logic          r_ovf;
  logic          r_dec_err;
  logic [BW-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_fcount;

  logic               w_is_dmem;
  logic               w_is_mmio;
  logic [2:0]         w_reg;
  logic [DMEM_AW-1:0] w_ram_idx;
  logic               w_dec_err;
  logic               w_wr_gpio;
  logic               w_wr_tcount;
  logic               w_wr_tcmp;
  logic               w_wr_status;
  logic               w_wr_tx;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_unused_addr;

  // Address decode; byte offset and aliased RAM bits are don't-care
  assign w_is_dmem    = (i_addr[31:16] == 16'h0000);
  assign w_is_mmio    = (i_addr[31:5] == 27'h080_0000);
  assign w_reg        = i_addr[4:2];
  assign w_ram_idx    = i_addr[DMEM_AW+1:2];
  assign w_dec_err    = !w_is_dmem && !(w_is_mmio && (w_reg <= REG_TX));
  assign w_unused_addr = ^{i_addr[1:0], i_addr[15:DMEM_AW+2]};

  assign w_wr_gpio   = i_wmem && w_is_mmio && (w_reg == REG_GPIO);
  assign w_wr_tcount = i_wmem && w_is_mmio && (w_reg == REG_TCOUNT);
  assign w_wr_tcmp   = i_wmem && w_is_mmio && (w_reg == REG_TCMP);
  assign w_wr_status = i_wmem && w_is_mmio && (w_reg == REG_STATUS);
  assign w_wr_tx     = i_wmem && w_is_mmio && (w_reg == REG_TX);

  assign w_fifo_full  = (r_fcount == CW'(FIFO_DEPTH));
  assign w_fifo_empty = (r_fcount == '0);
  assign w_pop        = !w_fifo_empty && i_tx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_push_ok    = w_wr_tx && (!w_fifo_full || w_pop);

  assign o_timer_irq = r_match;
  assign o_tx_valid  = !w_fifo_empty;
  assign o_tx_data   = w_fifo_empty ? '0 : r_fifo[r_rptr];

  always_ff @(posedge i_clk) begin
    if (i_wmem && w_is_dmem) begin
      r_ram[w_ram_idx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_gpio    <= '0;
      r_tcount  <= '0;
      r_tcmp    <= TIMER_CMP_RST;
      r_match   <= 1'b0;
      r_ovf     <= 1'b0;
      r_dec_err <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_fcount  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_wr_gpio) o_gpio <= i_wdata;
      if (w_wr_tcmp) r_tcmp <= i_wdata;
      r_tcount <= w_wr_tcount ? i_wdata : r_tcount + DW'(1);

      // Sticky flags: a set in the same cycle as a W1C wins
      if (r_tcount == r_tcmp)               r_match <= 1'b1;
      else if (w_wr_status && i_wdata[0])   r_match <= 1'b0;
      if (w_wr_tx && !w_push_ok)            r_ovf <= 1'b1;
      else if (w_wr_status && i_wdata[6])   r_ovf <= 1'b0;
      if (i_wmem && w_dec_err)              r_dec_err <= 1'b1;
      else if (w_wr_status && i_wdata[7])   r_dec_err <= 1'b0;

      if (w_push_ok) begin
        r_fifo[r_wptr] <= i_wdata[BW-1:0];
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_fcount <= r_fcount + CW'(1);
        2'b01:   r_fcount <= r_fcount - CW'(1);
        default: r_fcount <= r_fcount;
      endcase
    end
  end

  // Zero-latency load path
  always_comb begin
    o_rdata = '0;
    if (w_is_dmem) begin
      o_rdata = r_ram[w_ram_idx];
    end else if (w_is_mmio) begin
      case (w_reg)
        REG_GPIO:   o_rdata = o_gpio;
        REG_TCOUNT: o_rdata = r_tcount;
        REG_TCMP:   o_rdata = r_tcmp;
        REG_STATUS: o_rdata = {24'h0, r_dec_err, r_ovf, r_fcount,
                               w_fifo_empty, w_fifo_full, r_match};
        default:    o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: RAM, GPIO, FIFO, timer, decode error, reset.
module tb_dmem_mmio_bridge;

  localparam logic [31:0] A_GPIO   = 32'h1000_0000;
  localparam logic [31:0] A_TCOUNT = 32'h1000_0004;
  localparam logic [31:0] A_TCMP   = 32'h1000_0008;
  localparam logic [31:0] A_STATUS = 32'h1000_000C;
  localparam logic [31:0] A_TX     = 32'h1000_0010;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_wmem;
  logic [31:0] o_rdata;
  logic [31:0] o_gpio;
  logic        o_timer_irq;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_mmio_bridge dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_wmem      (i_wmem),
    .o_rdata     (o_rdata),
    .o_gpio      (o_gpio),
    .o_timer_irq (o_timer_irq),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    i_addr = a;
    #1;
    chk(tag, o_rdata, exp);
  endtask

  // Store issued on the falling edge, committed at the next rising edge; returns 1ns after it
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_addr  = a;
    i_wdata = d;
    i_wmem  = 1'b1;
    @(posedge i_clk);
    #1;
    i_wmem  = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [7:0] exp_b [4];

  initial begin
    i_reset    = 1'b1;
    i_addr     = '0;
    i_wdata    = '0;
    i_wmem     = 1'b0;
    i_tx_ready = 1'b0;
    #12;
    chk("rst_gpio", o_gpio, 32'h0);
    chk("rst_valid", 32'(o_tx_valid), 32'h0);
    chk("rst_data", 32'(o_tx_data), 32'h0);
    chk("rst_irq", 32'(o_timer_irq), 32'h0);
    rd("rst_status", A_STATUS, 32'h0000_0004);
    rd("rst_tcount", A_TCOUNT, 32'h0);
    rd("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    @(negedge i_clk);
    i_reset = 1'b0;

    // RAM write, byte-offset and region aliasing
    wr(32'h0000_0040, 32'hDEAD_BEEF);
    rd("ram_40", 32'h0000_0040, 32'hDEAD_BEEF);
    rd("ram_43", 32'h0000_0043, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_0440, 32'hDEAD_BEEF);
    rd("unmapped_rd", 32'h0001_0040, 32'h0);

    wr(A_GPIO, 32'h1234_5678);
    chk("gpio_out", o_gpio, 32'h1234_5678);
    rd("gpio_rd", A_GPIO, 32'h1234_5678);

    // FIFO fill with UART stalled: fifth byte overflows
    for (int b = 8'h41; b <= 8'h45; b++) wr(A_TX, 32'(b));
    rd("fifo_full_st", A_STATUS, 32'h0000_0062);
    chk("fifo_valid", 32'(o_tx_valid), 32'h1);
    chk("fifo_head", 32'(o_tx_data), 32'h41);
    rd("tx_rd_zero", A_TX, 32'h0);
    wr(A_STATUS, 32'h0000_0040);
    rd("ovf_clr", A_STATUS, 32'h0000_0022);

    // Push into a full FIFO while the head is popped
    i_tx_ready = 1'b1;
    wr(A_TX, 32'h55);
    i_tx_ready = 1'b0;
    rd("full_pop_push", A_STATUS, 32'h0000_0022);
    chk("head_after_pop", 32'(o_tx_data), 32'h42);

    exp_b = '{8'h42, 8'h43, 8'h44, 8'h55};
    i_tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_valid%0d", k), 32'(o_tx_valid), 32'h1);
      chk($sformatf("drain_data%0d", k), 32'(o_tx_data), 32'(exp_b[k]));
      tick();
    end
    i_tx_ready = 1'b0;
    chk("drained_valid", 32'(o_tx_valid), 32'h0);
    rd("drained_status", A_STATUS, 32'h0000_0004);

    // Decode error
    wr(32'h2000_0000, 32'hFFFF_FFFF);
    rd("decerr_status", A_STATUS, 32'h0000_0084);
    rd("decerr_rd", 32'h2000_0000, 32'h0);
    chk("decerr_gpio", o_gpio, 32'h1234_5678);
    rd("decerr_ram", 32'h0000_0040, 32'hDEAD_BEEF);
    wr(A_STATUS, 32'h0000_0080);
    rd("decerr_clr", A_STATUS, 32'h0000_0004);

    // Timer compare: flag appears after the sixth edge following COUNT=0
    wr(A_TCMP, 32'd5);
    wr(A_TCOUNT, 32'd0);
    rd("tcount_load", A_TCOUNT, 32'd0);
    rd("tcmp_rd", A_TCMP, 32'd5);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("irq_edge%0d", e), 32'(o_timer_irq), (e == 6) ? 32'h1 : 32'h0);
    end
    wr(A_STATUS, 32'h1);
    chk("irq_w1c", 32'(o_timer_irq), 32'h0);
    repeat (10) tick();
    chk("irq_stays_clr", 32'(o_timer_irq), 32'h0);

    // Wrap through 0xFFFFFFFF back to 5
    wr(A_TCOUNT, 32'hFFFF_FFFE);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 2) rd("tcount_wrap", A_TCOUNT, 32'h0);
      if (e == 7) chk("irq_wrap_pre", 32'(o_timer_irq), 32'h0);
      if (e == 8) chk("irq_wrap_set", 32'(o_timer_irq), 32'h1);
    end

    // Set beats a same-cycle W1C
    wr(A_STATUS, 32'h1);
    chk("irq_clr2", 32'(o_timer_irq), 32'h0);
    wr(A_TCOUNT, 32'd5);
    wr(A_STATUS, 32'h1);
    chk("irq_set_wins", 32'(o_timer_irq), 32'h1);

    // Asynchronous reset mid-stream
    for (int b = 8'h61; b <= 8'h63; b++) wr(A_TX, 32'(b));
    wr(A_GPIO, 32'h0000_00A5);
    chk("pre_rst_valid", 32'(o_tx_valid), 32'h1);
    chk("pre_rst_gpio", o_gpio, 32'h0000_00A5);
    #1;
    i_reset = 1'b1;
    #1;
    chk("arst_valid", 32'(o_tx_valid), 32'h0);
    chk("arst_gpio", o_gpio, 32'h0);
    chk("arst_irq", 32'(o_timer_irq), 32'h0);
    chk("arst_data", 32'(o_tx_data), 32'h0);
    #1;
    i_reset = 1'b0;
    rd("arst_status", A_STATUS, 32'h0000_0004);
    rd("arst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    tick();
    rd("arst_ram", 32'h0000_0040, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
